// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register occupancy states and counter width.
// Revision: 1.0
`default_nettype none

package cpu_types_pkg;

   localparam int PIPE_CNT_W = 32;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by the asynchronous reset.
// Revision: 1.0
`default_nettype none

module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, NOP bubbles and optional skid entry.
// Optional perf counters enabled by macro PIPE_STAGE_PERF_EN. Revision: 1.0
`default_nettype none

module pipe_stage_reg
   import cpu_types_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               SKID      = 1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [PIPE_CNT_W-1:0] stall_cnt,
   output logic [PIPE_CNT_W-1:0] bubble_cnt
`endif
);

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         pipe_state_t      state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic [WIDTH-1:0] skid_q, skid_d;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               state_q <= PS_EMPTY;
               main_q  <= NOP_VALUE;
               skid_q  <= NOP_VALUE;
            end else begin
               state_q <= state_d;
               main_q  <= main_d;
               skid_q  <= skid_d;
            end
         end

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
               state_d = PS_EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end else begin
               case (state_q)
                  PS_EMPTY: begin
                     if (in_fire) begin
                        main_d  = in_data;
                        state_d = PS_ONE;
                     end
                  end
                  PS_ONE: begin
                     if (in_fire && out_fire) begin
                        main_d = in_data;
                     end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = PS_TWO;
                     end else if (out_fire) begin
                        main_d  = NOP_VALUE;
                        state_d = PS_EMPTY;
                     end
                  end
                  PS_TWO: begin
                     if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                        state_d = PS_ONE;
                     end
                  end
                  default: begin
                     state_d = PS_EMPTY;
                     main_d  = NOP_VALUE;
                     skid_d  = NOP_VALUE;
                  end
               endcase
            end
         end

         // in_ready depends only on flush and registered state, never on out_ready.
         always_comb begin
            in_ready  = !flush && (state_q != PS_TWO);
            out_valid = (state_q != PS_EMPTY);
            out_data  = main_q;
         end
      end else begin : g_single
         logic             main_v_q, main_v_d;
         logic [WIDTH-1:0] main_q, main_d;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               main_v_q <= 1'b0;
               main_q   <= NOP_VALUE;
            end else begin
               main_v_q <= main_v_d;
               main_q   <= main_d;
            end
         end

         always_comb begin
            main_v_d = main_v_q;
            main_d   = main_q;
            if (flush) begin
               main_v_d = 1'b0;
               main_d   = NOP_VALUE;
            end else if (in_fire) begin
               main_v_d = 1'b1;
               main_d   = in_data;
            end else if (out_fire) begin
               main_v_d = 1'b0;
               main_d   = NOP_VALUE;
            end
         end

         always_comb begin
            in_ready  = !flush && (!main_v_q || out_ready);
            out_valid = main_v_q;
            out_data  = main_q;
         end
      end
   endgenerate

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(
      .W (PIPE_CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (out_valid & !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(
      .W (PIPE_CNT_W)
   ) u_bubble_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (!out_valid & out_ready),
      .count (bubble_cnt)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances checked against a queue model.
// Revision: 1.0
`default_nettype none

module tb_pipe_stage_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready1, out_valid1, in_ready0, out_valid0;
   logic [31:0] out_data1, out_data0;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall1, bubble1, stall0, bubble0;
`endif

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(1)) u_dut1 (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall1), .bubble_cnt(bubble1)
`endif
   );

   pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(0)) u_dut0 (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall0), .bubble_cnt(bubble0)
`endif
   );

   // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (single register).
   logic [31:0] q1[$];
   logic [31:0] q0[$];
   int          m_stall1, m_bubble1, m_stall0, m_bubble0;
   int          total = 0;
   int          passed = 0;
   int          failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      q1.delete();
      q0.delete();
      m_stall1 = 0; m_bubble1 = 0; m_stall0 = 0; m_bubble0 = 0;
   endtask

   // Drive inputs, check outputs at the falling edge, advance the model at the rising edge.
   task automatic tick(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
      logic rdy1, ov1, rdy0, ov0;
      logic [31:0] od1, od0;
      in_valid = v; in_data = d; out_ready = ordy; flush = fl;
      rdy1 = !fl && (q1.size() < 2);
      ov1  = (q1.size() > 0);
      od1  = ov1 ? q1[0] : NOP;
      rdy0 = !fl && ((q0.size() == 0) || ordy);
      ov0  = (q0.size() > 0);
      od0  = ov0 ? q0[0] : NOP;
      @(negedge CLK);
      check("skid1 in_ready",  {31'd0, in_ready1},  {31'd0, rdy1});
      check("skid1 out_valid", {31'd0, out_valid1}, {31'd0, ov1});
      check("skid1 out_data",  out_data1, od1);
      check("skid0 in_ready",  {31'd0, in_ready0},  {31'd0, rdy0});
      check("skid0 out_valid", {31'd0, out_valid0}, {31'd0, ov0});
      check("skid0 out_data",  out_data0, od0);
`ifdef PIPE_STAGE_PERF_EN
      check("skid1 stall_cnt",  stall1,  m_stall1);
      check("skid1 bubble_cnt", bubble1, m_bubble1);
      check("skid0 stall_cnt",  stall0,  m_stall0);
      check("skid0 bubble_cnt", bubble0, m_bubble0);
`endif
      @(posedge CLK);
      if (ov1 && !ordy) m_stall1++;
      if (!ov1 && ordy) m_bubble1++;
      if (ov0 && !ordy) m_stall0++;
      if (!ov0 && ordy) m_bubble0++;
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (ov1 && ordy) void'(q1.pop_front());
         if (v && rdy1) q1.push_back(d);
         if (ov0 && ordy) void'(q0.pop_front());
         if (v && rdy0) q0.push_back(d);
      end
      #1;
   endtask

   // Called just after a rising edge; reset is asserted and released between edges.
   task automatic reset_pulse();
      #1 nRST = 1'b0;
      #1;
      check("async rst out_valid1", {31'd0, out_valid1}, 32'd0);
      check("async rst out_data1",  out_data1, NOP);
      check("async rst in_ready1",  {31'd0, in_ready1}, {31'd0, !flush});
      check("async rst out_valid0", {31'd0, out_valid0}, 32'd0);
      check("async rst out_data0",  out_data0, NOP);
      #1 nRST = 1'b1;
      clear_model();
   endtask

   initial begin
      clear_model();
      #12;
      check("reset out_valid1", {31'd0, out_valid1}, 32'd0);
      check("reset out_data1",  out_data1, NOP);
      check("reset in_ready1",  {31'd0, in_ready1}, 32'd1);
      check("reset out_data0",  out_data0, NOP);
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Back-to-back stream with downstream always ready.
      tick(1'b1, 32'h1, 1'b1, 1'b0);
      check("stream first word", out_data1, 32'h1);
      tick(1'b1, 32'h2, 1'b1, 1'b0);
      check("stream second word", out_data1, 32'h2);
      tick(1'b1, 32'h3, 1'b1, 1'b0);
      check("stream third word", out_data1, 32'h3);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b1, 1'b0);

      // Skid absorption: A held, B into skid, C waits.
      tick(1'b1, 32'hA, 1'b0, 1'b0);
      tick(1'b1, 32'hB, 1'b0, 1'b0);
      check("skid full in_ready", {31'd0, in_ready1}, 32'd0);
      check("skid full head", out_data1, 32'hA);
      tick(1'b1, 32'hC, 1'b0, 1'b0);
      tick(1'b1, 32'hC, 1'b1, 1'b0);
      check("skid drain B", out_data1, 32'hB);
      tick(1'b1, 32'hC, 1'b1, 1'b0);
      check("skid drain C", out_data1, 32'hC);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b1, 1'b0);

      // Single-register mode: combinational in_ready and simultaneous replace.
      tick(1'b1, 32'h55, 1'b0, 1'b0);
      tick(1'b1, 32'h66, 1'b0, 1'b0);
      check("single held word", out_data0, 32'h55);
      tick(1'b1, 32'h66, 1'b1, 1'b0);
      check("single replace data", out_data0, 32'h66);
      check("single replace valid", {31'd0, out_valid0}, 32'd1);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush while full.
      tick(1'b1, 32'h11, 1'b0, 1'b0);
      tick(1'b1, 32'h22, 1'b0, 1'b0);
      tick(1'b1, 32'h33, 1'b0, 1'b1);
      check("flush out_valid1", {31'd0, out_valid1}, 32'd0);
      check("flush out_data1", out_data1, NOP);
      tick(1'b1, 32'h44, 1'b0, 1'b0);
      check("post-flush accept", out_data1, 32'h44);

      // Asynchronous reset while holding a word.
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b1, 32'hDEAD, 1'b0, 1'b0);
      in_valid = 1'b0;
      reset_pulse();

`ifdef PIPE_STAGE_PERF_EN
      @(posedge CLK); #1;
      reset_pulse();
      tick(1'b1, 32'h77, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
      check("perf stall_cnt",  stall1,  32'd10);
      check("perf bubble_cnt", bubble1, 32'd4);
`endif

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 3) != 0), $urandom(),
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register with valid/ready handshake, synchronous flush, NOP bubble insertion and an optional two-entry skid buffer. It replaces hand-written fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage packs its control and data fields into one `WIDTH`-bit word. Stall is expressed as back-pressure (`out_ready` low) instead of a write enable.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥ 1.
- `NOP_VALUE`, `'0`: `WIDTH`-bit word presented on `out_data` when empty and loaded into storage on reset or flush.
- `SKID`, 1: 0 gives a single register with combinational `in_ready`; 1 gives a two-entry skid buffer with registered `in_ready`.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  stage will accept a word this cycle.
- `in_data`  in  `WIDTH`  upstream payload.
- `out_valid`  out  1  `out_data` holds a live word.
- `out_ready`  in  1  downstream consumes a word this cycle.
- `out_data`  out  `WIDTH`  payload; equals `NOP_VALUE` when `out_valid`=0.
- `stall_cnt`  out  32  present only with `PIPE_STAGE_PERF_EN`; counts stall cycles (see Configuration).
- `bubble_cnt`  out  32  present only with `PIPE_STAGE_PERF_EN`; counts bubble cycles (see Configuration).

## Operation
- Handshake events:
  - `in_fire` = `in_valid & in_ready`.
  - `out_fire` = `out_valid & out_ready`.
- Producer and consumer rules:
  - Producer must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
  - The stage holds `out_data` stable while `out_valid` is high and `out_ready` is low.
- SKID=0:
  - Storage is one entry, `main_d` with valid bit `main_v`.
  - `in_ready` = `!flush & (!main_v | out_ready)`.
  - On `in_fire`: `main_d` ← `in_data`, `main_v` ← 1.
  - Otherwise, on `out_fire`: `main_v` ← 0 and `main_d` ← `NOP_VALUE`.
- SKID=1:
  - Storage is two entries, `main_d` and `skid_d`.
  - FSM states are `PS_EMPTY`, `PS_ONE` and `PS_TWO`.
  - `in_ready` = `!flush & (state != PS_TWO)`. The state term is a register output, so no combinational path exists from `out_ready`.
  - `PS_EMPTY`: on `in_fire`, load `main_d` and go to `PS_ONE`.
  - `PS_ONE`, `in_fire & out_fire`: `main_d` ← `in_data`, stay in `PS_ONE`.
  - `PS_ONE`, `in_fire` only: `skid_d` ← `in_data`, go to `PS_TWO`.
  - `PS_ONE`, `out_fire` only: go to `PS_EMPTY` and load `main_d` with `NOP_VALUE`.
  - `PS_TWO`: on `out_fire`, `main_d` ← `skid_d`, `skid_d` ← `NOP_VALUE`, go to `PS_ONE`. No input is accepted in this state.
- Outputs in both modes:
  - `out_valid` = (state != `PS_EMPTY`), or `main_v` when SKID=0.
  - `out_data` = `main_d`.
- Flush has the highest priority:
  - `in_ready` is forced to 0, so the input is never accepted during a flush cycle.
  - On the next edge, all entries are emptied and all data registers are loaded with `NOP_VALUE`.
  - `out_valid` is not gated during the flush cycle. A beat with `out_valid & out_ready` in that cycle counts as delivered.
- Ordering is strictly FIFO. No word is duplicated or dropped except by flush.

## Timing
- Reset (`nRST`=0, asynchronous):
  - state = `PS_EMPTY`, `main_v` = 0.
  - `main_d` = `skid_d` = `NOP_VALUE`.
  - `out_valid` = 0, `out_data` = `NOP_VALUE`.
  - `in_ready` = 1 (when `flush`=0).
  - Counters = 0.
- Reset asserted mid-transfer discards all held words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle with `out_ready` held high, in both modes.
- SKID=1: `in_ready` falls one cycle after the first cycle of `out_ready`=0 with the stage holding a word. The word arriving in that cycle is absorbed into `skid_d`.
- Simultaneous flush and reset: reset dominates.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `out_valid & !out_ready`.
  - `bubble_cnt` increments on every cycle with `!out_valid & out_ready`.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared only by reset; flush does not clear them.
- `PIPE_STAGE_PERF_EN` undefined: the counter ports and their logic are absent.

## Structure
- Add to `cpu_types_pkg`:
  - typedef `pipe_state_t` (`PS_EMPTY`, `PS_ONE`, `PS_TWO`), 2 bits.
  - constant `PIPE_CNT_W` = 32.
- Sub-module `sat_counter`, parametrised on width, with inputs `inc` and outputs `count`. It is instantiated twice under the macro.

## Test plan
- SKID=1, `out_ready`=1, stream 0x1, 0x2, 0x3 on consecutive cycles → same words appear one cycle later, back to back; `in_ready` stays 1.
- SKID=1: load 0xA, drop `out_ready`, present 0xB then 0xC → 0xB accepted into skid, `in_ready`=0 while 0xC waits. Raising `out_ready` gives the output sequence 0xA, 0xB, 0xC.
- SKID=0, stage holds 0x55, `out_ready`=0 → `in_ready`=0 combinationally. `out_ready`=1 with `in_valid` (0x66) in the same cycle → 0x66 is loaded and `out_valid` stays 1.
- Flush with state `PS_TWO` → `in_ready`=0 that cycle; next cycle `out_valid`=0, `out_data`=`NOP_VALUE` (e.g. 32'h0000_0000), and the following `in_valid` is accepted.
- `nRST` pulsed low between edges while the stage holds 0xDEAD → `out_valid` drops at once and `out_data` = `NOP_VALUE`.
- `PIPE_STAGE_PERF_EN`, hold word with `out_ready`=0 for 10 cycles, then empty with `out_ready`=1 for 4 cycles → `stall_cnt`=10, `bubble_cnt`=4.
